// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared types and helpers for the DMA write-side master.
//   state_e         : write-master FSM states
//   RESP_OKAY/SLVERR: AXI write response codes
//   wstrb_from_rem  : byte strobe for a beat given the bytes still to move
// ---------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_RESP,
        ST_DONE
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Full word when at least four bytes remain, otherwise a low-aligned mask.
    function automatic logic [3:0] wstrb_from_rem(input int unsigned rem);
        logic [3:0] strb;
        if (rem >= 4)
            strb = 4'hF;
        else if (rem == 3)
            strb = 4'h7;
        else if (rem == 2)
            strb = 4'h3;
        else if (rem == 1)
            strb = 4'h1;
        else
            strb = 4'h0;
        return strb;
    endfunction

endpackage

// File: rtl/dma_axil_write_master.sv
// ---------------------------------------------------------------------------
// dma_axil_write_master
// Drains words from the DMA internal stream and writes them to a destination
// AXI4-Lite slave as single-beat writes to incrementing word addresses.
// The last beat of a command is byte-masked through WSTRB.
//
// Ports
//   clk, rst              : clock (posedge), asynchronous active-low reset
//   start, dst_addr,
//   length                : command strobe, byte address, byte count
//   busy, done, error     : status back to the DMA control block
//   s_data/s_valid/s_ready: stream input from the read side
//   AW*, W*, B*           : AXI4-Lite write channels toward the slave
// ---------------------------------------------------------------------------
module dma_axil_write_master
    import dma_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = 32,
    parameter int unsigned MAX_LENGTH = 16,
    parameter int unsigned LEN        = $clog2(MAX_LENGTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 start,
    input  logic [DATAWIDTH-1:0] dst_addr,
    input  logic [LEN-1:0]       length,
    output logic                 busy,
    output logic                 done,
    output logic                 error,

    input  logic [DATAWIDTH-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,

    output logic [DATAWIDTH-1:0] AWADDR,
    output logic                 AWVALID,
    output logic [2:0]           AWPROT,
    input  logic                 AWREADY,
    output logic [DATAWIDTH-1:0] WDATA,
    output logic [3:0]           WSTRB,
    output logic                 WVALID,
    input  logic                 WREADY,
    input  logic [1:0]           BRESP,
    input  logic                 BVALID,
    output logic                 BREADY
);

    state_e               state_q;
    logic [DATAWIDTH-1:0] cur_addr_q;
    logic [LEN-1:0]       rem_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic                 s_ready_q;
    logic                 awvalid_q;
    logic                 wvalid_q;
    logic                 bready_q;
    logic [DATAWIDTH-1:0] awaddr_q;
    logic [DATAWIDTH-1:0] wdata_q;
    logic [3:0]           wstrb_q;
    logic                 aw_done_q;
    logic                 w_done_q;

    logic                 s_hs;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 b_hs;
    logic                 len_too_long;
    logic [LEN-1:0]       rem_d;
    logic [DATAWIDTH-1:0] addr_d;
    logic [DATAWIDTH-1:0] start_addr_d;

    always_comb begin
        s_hs         = s_valid & s_ready_q;
        aw_hs        = awvalid_q & AWREADY;
        w_hs         = wvalid_q & WREADY;
        b_hs         = BVALID & bready_q;
        len_too_long = 32'(length) > MAX_LENGTH;
        rem_d        = (rem_q >= LEN'(4)) ? rem_q - LEN'(4) : '0;
        addr_d       = cur_addr_q + DATAWIDTH'(4);
        start_addr_d = dst_addr & ~DATAWIDTH'(3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            s_ready_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr_q <= start_addr_d;
                        rem_q      <= length;
                        error_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        if (length == '0) begin
                            state_q <= ST_DONE;
                        end else if (len_too_long) begin
                            error_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            s_ready_q <= 1'b1;
                            state_q   <= ST_FETCH;
                        end
                    end
                end

                ST_FETCH: begin
                    if (s_hs) begin
                        s_ready_q <= 1'b0;
                        wdata_q   <= s_data;
                        awaddr_q  <= cur_addr_q;
                        wstrb_q   <= wstrb_from_rem(32'(rem_q));
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end

                // AW and W complete independently; the done flags remember
                // a channel that finished in an earlier cycle.
                ST_ISSUE: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        if (BRESP != RESP_OKAY) begin
                            error_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            rem_q      <= rem_d;
                            cur_addr_q <= addr_d;
                            if (rem_d == '0) begin
                                state_q <= ST_DONE;
                            end else begin
                                s_ready_q <= 1'b1;
                                state_q   <= ST_FETCH;
                            end
                        end
                    end
                end

                // First DONE cycle raises done; second drops done and busy
                // together, so start stays ignored while done is visible.
                ST_DONE: begin
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign s_ready = s_ready_q;
    assign AWADDR  = awaddr_q;
    assign AWVALID = awvalid_q;
    assign AWPROT  = 3'b000;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;

endmodule
